// File: rtl/btb_lru_assoc.sv
// Fully associative branch target buffer with true-LRU replacement
// and per-entry saturating direction counters.
module btb_lru_assoc #(
    parameter int ENTRIES = 4,
    parameter int W_TAG   = 8,
    parameter int W_BTA   = 32,
    parameter int W_CNT   = 2,
    parameter int W_OCC   = $clog2(ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [31:0]      pc,
    input  logic             lookup_en,
    output logic             hit,
    output logic             predict_taken,
    output logic [W_BTA-1:0] bta,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [W_BTA-1:0] upd_target,
    input  logic             upd_taken,
    output logic [W_OCC-1:0] occupancy
);

    localparam int W_AGE = $clog2(ENTRIES);

    typedef logic [ENTRIES-1:0][W_AGE-1:0] age_t;

    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][W_TAG-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][W_BTA-1:0]  tgt_q, tgt_d;
    logic [ENTRIES-1:0][W_CNT-1:0]  cnt_q, cnt_d;
    age_t                           age_q, age_d;
    logic [W_OCC-1:0]               occ_q, occ_d;

    logic             lk_hit, up_hit, inv_found;
    logic [W_AGE-1:0] lk_idx, up_idx, inv_idx, lru_idx, vic_idx;

    logic unused_pc_hi;
    assign unused_pc_hi = ^{pc[31:W_TAG], upd_pc[31:W_TAG]};

    // Entry idx becomes MRU; entries younger than it age by one.
    function automatic age_t promote(input age_t a, input logic [W_AGE-1:0] idx);
        age_t r;
        r = a;
        for (int j = 0; j < ENTRIES; j++) begin
            if (a[j] < a[idx]) r[j] = a[j] + W_AGE'(1);
        end
        r[idx] = '0;
        return r;
    endfunction

    always_comb begin
        lk_hit    = 1'b0;
        lk_idx    = '0;
        up_hit    = 1'b0;
        up_idx    = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        lru_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == pc[W_TAG-1:0]) begin
                lk_hit = 1'b1;
                lk_idx = W_AGE'(i);
            end
            if (valid_q[i] && tag_q[i] == upd_pc[W_TAG-1:0]) begin
                up_hit = 1'b1;
                up_idx = W_AGE'(i);
            end
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = W_AGE'(i);
            end
            if (age_q[i] == W_AGE'(ENTRIES - 1)) lru_idx = W_AGE'(i);
        end
        vic_idx = inv_found ? inv_idx : lru_idx;
    end

    assign hit           = lk_hit;
    assign predict_taken = lk_hit && cnt_q[lk_idx][W_CNT-1];
    assign bta           = lk_hit ? tgt_q[lk_idx] : '0;
    assign occupancy     = occ_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        age_d   = age_q;
        occ_d   = occ_q;
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
            for (int i = 0; i < ENTRIES; i++) age_d[i] = W_AGE'(i);
        end else begin
            // Lookup promotion first so the update entry ends up MRU.
            if (lookup_en && lk_hit) age_d = promote(age_d, lk_idx);
            if (upd_valid && up_hit) begin
                if (upd_taken) begin
                    if (cnt_q[up_idx] != '1)
                        cnt_d[up_idx] = cnt_q[up_idx] + W_CNT'(1);
                    tgt_d[up_idx] = upd_target;
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_d[up_idx] = cnt_q[up_idx] - W_CNT'(1);
                end
                age_d = promote(age_d, up_idx);
            end else if (upd_valid && upd_taken) begin
                valid_d[vic_idx] = 1'b1;
                tag_d[vic_idx]   = upd_pc[W_TAG-1:0];
                tgt_d[vic_idx]   = upd_target;
                cnt_d[vic_idx]   = W_CNT'(1) << (W_CNT - 1);
                age_d            = promote(age_d, vic_idx);
                if (inv_found) occ_d = occ_q + W_OCC'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            occ_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) age_q[i] <= W_AGE'(i);
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_btb_lru_assoc.sv
// Directed self-checking bench for btb_lru_assoc (ENTRIES=4 default).
module tb_btb_lru_assoc;

    logic        clk = 1'b0;
    logic        reset, flush, lookup_en, upd_valid, upd_taken;
    logic [31:0] pc, upd_pc, upd_target, bta;
    logic        hit, predict_taken;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btb_lru_assoc dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .pc            (pc),
        .lookup_en     (lookup_en),
        .hit           (hit),
        .predict_taken (predict_taken),
        .bta           (bta),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .occupancy     (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t,
                       input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_target = t;
        upd_taken  = tk;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] p,
                        input logic eh, input logic [31:0] eb,
                        input logic ep);
        pc = p;
        #1;
        check({tag, ".hit"}, 32'(hit), 32'(eh));
        check({tag, ".bta"}, bta, eb);
        check({tag, ".pt"}, 32'(predict_taken), 32'(ep));
    endtask

    task automatic ages(input string tag, input logic [1:0] a0,
                        input logic [1:0] a1, input logic [1:0] a2,
                        input logic [1:0] a3);
        check({tag, ".age0"}, 32'(dut.age_q[0]), 32'(a0));
        check({tag, ".age1"}, 32'(dut.age_q[1]), 32'(a1));
        check({tag, ".age2"}, 32'(dut.age_q[2]), 32'(a2));
        check({tag, ".age3"}, 32'(dut.age_q[3]), 32'(a3));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; lookup_en = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        pc = '0;
        tick();
        tick();
        reset = 1'b0;

        lookup_en = 1'b1;
        look("rst", 32'h20, 1'b0, 32'h0, 1'b0);
        check("rst.occ", 32'(occupancy), 32'd0);
        ages("rst", 2'd0, 2'd1, 2'd2, 2'd3);
        lookup_en = 1'b0;

        upd(32'h08, 32'h110, 1'b1);
        look("alloc08", 32'h08, 1'b1, 32'h110, 1'b1);
        check("alloc08.occ", 32'(occupancy), 32'd1);

        // Counter: 2 -> 1 -> 0 -> 0 (not taken keeps old target)
        upd(32'h08, 32'hDEAD, 1'b0);
        look("nt1", 32'h08, 1'b1, 32'h110, 1'b0);
        upd(32'h08, 32'hDEAD, 1'b0);
        look("nt2", 32'h08, 1'b1, 32'h110, 1'b0);
        upd(32'h08, 32'hDEAD, 1'b0);
        look("nt3", 32'h08, 1'b1, 32'h110, 1'b0);
        check("nt3.cnt", 32'(dut.cnt_q[0]), 32'd0);
        // 0 -> 1 -> 2 -> 3 -> 3, then one not-taken gives 2
        upd(32'h08, 32'h120, 1'b1);
        look("t1", 32'h08, 1'b1, 32'h120, 1'b0);
        upd(32'h08, 32'h120, 1'b1);
        look("t2", 32'h08, 1'b1, 32'h120, 1'b1);
        upd(32'h08, 32'h120, 1'b1);
        upd(32'h08, 32'h120, 1'b1);
        check("sat.cnt", 32'(dut.cnt_q[0]), 32'd3);
        upd(32'h08, 32'h120, 1'b0);
        look("sat.nt", 32'h08, 1'b1, 32'h120, 1'b1);
        upd(32'h5C, 32'h500, 1'b0);
        check("ntmiss.occ", 32'(occupancy), 32'd1);

        upd(32'h12, 32'h212, 1'b1);
        upd(32'h16, 32'h216, 1'b1);
        upd(32'h1A, 32'h21A, 1'b1);
        check("fill.occ", 32'(occupancy), 32'd4);
        ages("fill", 2'd3, 2'd2, 2'd1, 2'd0);

        lookup_en = 1'b1;
        pc = 32'h08;
        tick();
        lookup_en = 1'b0;
        ages("lk08", 2'd0, 2'd3, 2'd2, 2'd1);

        upd(32'h20, 32'h200, 1'b1);
        look("evict12", 32'h12, 1'b0, 32'h0, 1'b0);
        look("keep08", 32'h08, 1'b1, 32'h120, 1'b1);
        look("new20", 32'h20, 1'b1, 32'h200, 1'b1);
        check("evict.occ", 32'(occupancy), 32'd4);
        ages("evict", 2'd1, 2'd0, 2'd3, 2'd2);

        lookup_en = 1'b1;
        pc = 32'h16;
        tick();
        pc = 32'h08;
        tick();
        ages("lk16_08", 2'd0, 2'd2, 2'd1, 2'd3);
        // Same cycle: lookup 0x16 and allocate 0x30 (evicts 0x1A)
        pc = 32'h16;
        upd(32'h30, 32'h300, 1'b1);
        lookup_en = 1'b0;
        ages("same", 2'd2, 2'd3, 2'd1, 2'd0);
        look("same.30", 32'h30, 1'b1, 32'h300, 1'b1);
        look("same.1A", 32'h1A, 1'b0, 32'h0, 1'b0);

        // Lookup hit on LRU entry 0x20 while allocation evicts it
        lookup_en = 1'b1;
        pc = 32'h20;
        upd(32'h40, 32'h400, 1'b1);
        lookup_en = 1'b0;
        ages("evlk", 2'd3, 2'd0, 2'd2, 2'd1);
        look("evlk.20", 32'h20, 1'b0, 32'h0, 1'b0);
        look("evlk.40", 32'h40, 1'b1, 32'h400, 1'b1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        upd(32'h08, 32'h108, 1'b1);
        upd(32'h12, 32'h112, 1'b1);
        upd(32'h16, 32'h116, 1'b1);
        check("three.occ", 32'(occupancy), 32'd3);
        flush = 1'b1;
        upd(32'h40, 32'h440, 1'b1);
        flush = 1'b0;
        check("flush.occ", 32'(occupancy), 32'd0);
        look("flush.08", 32'h08, 1'b0, 32'h0, 1'b0);
        look("flush.16", 32'h16, 1'b0, 32'h0, 1'b0);
        look("flush.40", 32'h40, 1'b0, 32'h0, 1'b0);
        ages("flush", 2'd0, 2'd1, 2'd2, 2'd3);

        upd(32'h08, 32'h108, 1'b1);
        check("pre_rst.occ", 32'(occupancy), 32'd1);
        reset = 1'b1;
        upd(32'h50, 32'h550, 1'b1);
        reset = 1'b0;
        check("rstupd.occ", 32'(occupancy), 32'd0);
        look("rstupd.50", 32'h50, 1'b0, 32'h0, 1'b0);
        look("rstupd.08", 32'h08, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
